// File: rtl/kmkz_ahb_pkg.sv
// Shared AHB-Lite definitions for the uRV bus fabric (bus matrix and slaves).
// Holds the HTRANS / HSIZE / HRESP codes, the slave FSM state encoding and a
// helper that derives little-endian byte lane enables from size and address.
package kmkz_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahb_htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } ahb_hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } ahb_hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_slv_state_e;

  // Little-endian lane enables; only meaningful for legal size/alignment.
  function automatic logic [3:0] ahb_byte_en(input logic [2:0] size,
                                             input logic [1:0] addr);
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/kmkz_sram_bytewr.sv
// Single-port word RAM with per-byte write enables and an asynchronous read.
// Kept separate from the bus FSM so a vendor BRAM can be dropped in later.
// Ports:
//   clk_i    write clock, rising edge
//   i_we     byte lane write enables (lane 0 = bits 7:0)
//   i_addr   word address (shared by read and write)
//   i_wdata  write data
//   o_rdata  combinational read of the addressed word
module kmkz_sram_bytewr #(
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];

  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/kmkz_ahb_sram.sv
// AHB-Lite responder backed by a word-organised RAM. Completes legal transfers
// with WAIT_STATES wait cycles and answers illegal ones (bad size, misaligned,
// out of range) with a two-cycle ERROR response without touching the RAM.
// Ports:
//   clk_i, rst_i        clock and asynchronous active-high reset
//   HSEL, HREADY        select and bus-level ready (accept qualifiers)
//   HADDR, HSIZE,
//   HTRANS, HWRITE      address phase; only HADDR[15:0] is decoded
//   HBURST, HMASTLOCK,
//   HPROT               ignored
//   HWDATA              write data, sampled at the end of the data phase
//   HRDATA              read data, non-zero only in the DATA state
//   HREADYOUT, HRESP    slave ready and response
module kmkz_ahb_sram
  import kmkz_ahb_pkg::*;
#(
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam logic [2:0] WCNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  ahb_slv_state_e    r_state;
  logic              r_hreadyout;
  ahb_hresp_e        r_hresp;
  logic [2:0]        r_wcnt;
  logic [MEM_AW+1:0] r_addr;
  logic [2:0]        r_size;
  logic              r_write;

  logic              w_active;
  logic              w_can_accept;
  logic              w_accept;
  logic              w_size_bad;
  logic              w_align_bad;
  logic              w_range_bad;
  logic              w_legal;
  logic [3:0]        w_we;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_active     = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_accept     = HSEL && HREADY && w_active && w_can_accept;

  always_comb begin
    w_size_bad  = HSIZE > HSIZE_WORD;
    w_align_bad = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                  ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    // For MEM_AW=14 the shift clears all 16 bits, so the range check vanishes.
    w_range_bad = (HADDR[15:0] >> (MEM_AW + 2)) != '0;
    w_legal     = !(w_size_bad || w_align_bad || w_range_bad);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_wcnt      <= '0;
      r_addr      <= '0;
      r_size      <= '0;
      r_write     <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_wcnt == '0) begin
            r_state     <= ST_DATA;
            r_hreadyout <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt - 3'd1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        // IDLE, DATA and ERR2 all take a new address phase the same way.
        default: begin
          if (w_accept) begin
            r_addr  <= HADDR[MEM_AW+1:0];
            r_size  <= HSIZE;
            r_write <= HWRITE;
            if (!w_legal) begin
              r_state     <= ST_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              r_state     <= ST_WAIT;
              r_wcnt      <= WCNT_INIT;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_OKAY;
            end else begin
              r_state     <= ST_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= HRESP_OKAY;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // The write commits on the edge that closes DATA, with HWDATA valid then.
  assign w_we = ((r_state == ST_DATA) && r_write) ? ahb_byte_en(r_size, r_addr[1:0]) : '0;

  kmkz_sram_bytewr #(
    .AW (MEM_AW)
  ) u_ram (
    .clk_i   (clk_i),
    .i_we    (w_we),
    .i_addr  (r_addr[MEM_AW+1:2]),
    .i_wdata (HWDATA),
    .o_rdata (w_rdata)
  );

  assign HRDATA    = (r_state == ST_DATA) ? w_rdata : '0;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

  assign w_unused = ^{HBURST, HMASTLOCK, HPROT, HADDR[31:16]};

endmodule

// File: tb/tb_kmkz_ahb_sram.sv
module tb_kmkz_ahb_sram;

  localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010, SX = 3'b011;

  typedef struct {
    logic        sel3;
    logic        hsel;
    logic        hren;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rdy;
    logic        exp_resp;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  logic        clk = 1'b0;
  logic        rst0, rst3, hsel0, hsel3, hren, hwrite;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] rd0, rd3;
  logic        rdy0, rdy3, resp0, resp3;
  logic        hready0, hready3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign hready0 = rdy0 & hren;
  assign hready3 = rdy3 & hren;

  kmkz_ahb_sram #(.MEM_AW(10), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst0), .HSEL(hsel0), .HADDR(haddr), .HBURST(3'b000),
    .HMASTLOCK(1'b0), .HPROT(4'b0011), .HSIZE(hsize), .HTRANS(htrans),
    .HWDATA(hwdata), .HWRITE(hwrite), .HREADY(hready0),
    .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(resp0));

  kmkz_ahb_sram #(.MEM_AW(10), .WAIT_STATES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .HSEL(hsel3), .HADDR(haddr), .HBURST(3'b000),
    .HMASTLOCK(1'b0), .HPROT(4'b0011), .HSIZE(hsize), .HTRANS(htrans),
    .HWDATA(hwdata), .HWRITE(hwrite), .HREADY(hready3),
    .HRDATA(rd3), .HREADYOUT(rdy3), .HRESP(resp3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic add(input logic s3, input logic hs, input logic hr, input logic [1:0] tr,
                     input logic wr, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic rdy, input logic resp,
                     input logic ck, input logic [31:0] rd);
    vec_t v;
    v.sel3 = s3; v.hsel = hs; v.hren = hr; v.trans = tr; v.wr = wr; v.size = sz;
    v.addr = a; v.wdata = wd; v.exp_rdy = rdy; v.exp_resp = resp; v.chk_rd = ck; v.exp_rd = rd;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic s3, input logic hs, input logic hr, input logic [1:0] tr,
                       input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    hsel0 = hs & ~s3; hsel3 = hs & s3; hren = hr; htrans = tr;
    hwrite = wr; hsize = sz; haddr = a; hwdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // WAIT_STATES=0 instance: pipelined write/read, byte and half lanes
    add(0,1,1,TN,1,SW,32'h0010,32'h0,        1,0,1,32'h0);
    add(0,1,1,TN,0,SW,32'h0010,32'hDEADBEEF, 1,0,0,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'hDEADBEEF);
    add(0,1,1,TN,1,SW,32'h0010,32'h0,        1,0,1,32'h0);
    add(0,1,1,TN,1,SW,32'h0014,32'h0,        1,0,0,32'h0);
    add(0,1,1,TN,1,SB,32'h0011,32'hFFFFFFFF, 1,0,0,32'h0);
    add(0,1,1,TN,1,SH,32'h0016,32'h1122AA44, 1,0,0,32'h0);
    add(0,1,1,TN,0,SW,32'h0010,32'h12345678, 1,0,0,32'h0);
    add(0,1,1,TN,0,SW,32'h0014,32'h0,        1,0,1,32'h0000AA00);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'h1234FFFF);
    // no-accept cases: BUSY, unselected, HREADY low; then SEQ read proves RAM untouched
    add(0,1,1,TB,1,SW,32'h0010,32'hFFFFFFFF, 1,0,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'hFFFFFFFF, 1,0,1,32'h0);
    add(0,0,1,TN,1,SW,32'h0010,32'hFFFFFFFF, 1,0,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'hFFFFFFFF, 1,0,1,32'h0);
    add(0,1,0,TN,1,SW,32'h0010,32'hFFFFFFFF, 1,0,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'hFFFFFFFF, 1,0,1,32'h0);
    add(0,1,1,TS,0,SW,32'h0010,32'h0,        1,0,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'h0000AA00);
    // top legal word
    add(0,1,1,TN,1,SW,32'h0FFC,32'h0,        1,0,1,32'h0);
    add(0,1,1,TN,0,SW,32'h0FFC,32'hA5A50FFC, 1,0,0,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'hA5A50FFC);
    // misaligned word read, then legal NONSEQ in ERR2
    add(0,1,1,TN,1,SW,32'h0000,32'h0,        1,0,1,32'h0);
    add(0,1,1,TN,0,SW,32'h0002,32'hCAFEF00D, 1,0,0,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        0,1,1,32'h0);
    add(0,1,1,TN,0,SW,32'h0000,32'h0,        1,1,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'hCAFEF00D);
    // HSIZE=011 write
    add(0,1,1,TN,1,SX,32'h0000,32'h0,        1,0,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'hFFFFFFFF, 0,1,1,32'h0);
    add(0,1,1,TN,0,SW,32'h0000,32'hFFFFFFFF, 1,1,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'hCAFEF00D);
    // misaligned half write
    add(0,1,1,TN,1,SH,32'h0001,32'h0,        1,0,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'hFFFFFFFF, 0,1,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'hFFFFFFFF, 1,1,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'h0);
    // out of range write aliasing word 0
    add(0,1,1,TN,1,SW,32'h1000,32'h0,        1,0,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'hFFFFFFFF, 0,1,1,32'h0);
    add(0,1,1,TN,0,SW,32'h0000,32'hFFFFFFFF, 1,1,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'hCAFEF00D);
    // HADDR[31:16] not decoded
    add(0,1,1,TN,0,SW,32'h00010000,32'h0,    1,0,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'hCAFEF00D);
    // back-to-back errors
    add(0,1,1,TN,0,SW,32'h0003,32'h0,        1,0,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        0,1,1,32'h0);
    add(0,1,1,TN,0,SB,32'h2000,32'h0,        1,1,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        0,1,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        1,1,1,32'h0);
    add(0,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'h0);
    // WAIT_STATES=3 instance: write then pipelined read @0x20
    add(1,1,1,TN,1,SW,32'h0020,32'h0,        1,0,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h600DCAFE, 0,0,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h600DCAFE, 0,0,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h600DCAFE, 0,0,1,32'h0);
    add(1,1,1,TN,0,SW,32'h0020,32'h600DCAFE, 1,0,0,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h0,        0,0,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h0,        0,0,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h0,        0,0,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'h600DCAFE);
    add(1,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'h0);
    // errors skip the wait states
    add(1,1,1,TN,0,SH,32'h0021,32'h0,        1,0,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h0,        0,1,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h0,        1,1,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'h0);
    // preload @0x30 for the reset sequence
    add(1,1,1,TN,1,SW,32'h0030,32'h0,        1,0,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h11111111, 0,0,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h11111111, 0,0,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h11111111, 0,0,1,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h11111111, 1,0,0,32'h0);
    add(1,1,1,TI,0,SW,32'h0,   32'h0,        1,0,1,32'h0);

    rst0 = 1'b1; rst3 = 1'b1;
    drive(0,0,1,TI,0,SW,32'h0,32'h0);
    #12;
    chk("rst0_rdy",  {31'b0, rdy0},  32'd1);
    chk("rst0_resp", {31'b0, resp0}, 32'd0);
    chk("rst0_rd",   rd0,            32'h0);
    chk("rst3_rdy",  {31'b0, rdy3},  32'd1);
    chk("rst3_resp", {31'b0, resp3}, 32'd0);
    chk("rst3_rd",   rd3,            32'h0);
    @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      @(posedge clk); #1;
      drive(v.sel3, v.hsel, v.hren, v.trans, v.wr, v.size, v.addr, v.wdata);
      @(negedge clk);
      chk($sformatf("row%0d_rdy", i),  {31'b0, v.sel3 ? rdy3 : rdy0},   {31'b0, v.exp_rdy});
      chk($sformatf("row%0d_resp", i), {31'b0, v.sel3 ? resp3 : resp0}, {31'b0, v.exp_resp});
      if (v.chk_rd) chk($sformatf("row%0d_rdata", i), v.sel3 ? rd3 : rd0, v.exp_rd);
    end

    // Reset during the 2nd wait cycle of a write of 0x55 to @0x30
    @(posedge clk); #1;
    drive(1,1,1,TN,1,SW,32'h0030,32'h00000055);
    @(posedge clk); #1;
    drive(1,1,1,TI,0,SW,32'h0,32'h00000055);
    @(posedge clk); #1;
    chk("rstseq_in_wait", {31'b0, rdy3}, 32'd0);
    #2 rst3 = 1'b1;
    #1;
    chk("rstseq_rdy",  {31'b0, rdy3},  32'd1);
    chk("rstseq_resp", {31'b0, resp3}, 32'd0);
    chk("rstseq_rd",   rd3,            32'h0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    @(posedge clk); #1;
    drive(1,1,1,TN,0,SW,32'h0030,32'h0);
    @(posedge clk); #1;
    drive(1,1,1,TI,0,SW,32'h0,32'h0);
    begin
      int n;
      bit done;
      done = 1'b0;
      n = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (rdy3) begin
          done = 1'b1;
          break;
        end
        n++;
      end
      chk("rstseq_read_done",  {31'b0, done}, 32'd1);
      chk("rstseq_read_waits", n,             32'd3);
      chk("rstseq_read_data",  rd3,           32'h11111111);
      chk("rstseq_read_resp",  {31'b0, resp3}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kmkz_ahb_sram.md
Name: kmkz_ahb_sram

Overview:
- AHB-Lite responder (slave) with internal word-organised RAM, placed behind the uRV bus matrix on the external data port or the debug port.
- Receives transfers the matrix forwards and completes them with a configurable number of wait states.
- Gives a two-cycle ERROR response for illegal transfers.
- Used as tightly-coupled data RAM and as the debug scratch window.

Parameters:
- MEM_AW, 10, log2 of depth in 32-bit words (1..14); usable offset range 0 .. 4*2^MEM_AW-1.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per valid OKAY transfer (0..7).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- HSEL  in  1  slave select from matrix decoder
- HADDR  in  32  address; only [15:0] used
- HBURST  in  3  ignored (every beat treated independently)
- HMASTLOCK  in  1  ignored
- HPROT  in  4  ignored
- HSIZE  in  3  000 byte, 001 half, 010 word; others illegal
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWDATA  in  32  write data, data phase
- HWRITE  in  1  1 = write
- HREADY  in  1  bus-level ready (HREADYIN)
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 OKAY, 1 ERROR

Behaviour:
- Reset (async, rst_i=1): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0, latched address-phase registers cleared. RAM contents are not reset. Any pending write is discarded.
- Accept: an address phase is taken on a rising edge when HSEL && HREADY && HTRANS[1]. HADDR[15:0], HSIZE and HWRITE are latched. IDLE, BUSY or unselected cycles take no action and give a zero-wait OKAY.
- Legality is checked at accept. A transfer is illegal if any of these hold:
  - HSIZE > 010
  - halfword with HADDR[0]=1
  - word with HADDR[1:0]!=0
  - HADDR[15:MEM_AW+2] != 0 (skip this check if MEM_AW=14)
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on a legal accept, go to WAIT if WAIT_STATES>0 (counter=WAIT_STATES-1), else DATA. On an illegal accept, go to ERR1. Otherwise stay.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements; go to DATA when it is 0.
  - DATA: HREADYOUT=1, HRESP=0; the transfer completes this cycle. A new accept in the same cycle is allowed (pipelining) and follows the IDLE rules. Otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; next state ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept here follows the IDLE rules, so back-to-back is allowed. No RAM access for the errored transfer.
- Latency:
  - Zero-wait read: data is valid in the cycle after the address phase.
  - N waits: data is valid N+1 cycles after the address phase.
- Read: in DATA, HRDATA = ram[latched addr[MEM_AW+1:2]] as the full word; byte lanes are not masked. HRDATA=0 in every other state.
- Write:
  - Commits at the rising edge that ends the DATA state, using HWDATA sampled at that edge.
  - Little-endian byte enables from the latched size and addr[1:0]. Byte: lane addr[1:0]. Half: lanes {addr[1],0} and {addr[1],1}. Word: all 4 lanes.
  - Other lanes are unchanged.
- Read-after-write to the same word, back-to-back: the read's DATA cycle follows the write's commit edge and must return the new data. No forwarding is needed.
- HREADY low (another slave stalling) during IDLE: no accept.
- Reset asserted mid-WAIT or mid-ERR1 returns to IDLE immediately (outputs at reset values). No partial write.

Decomposition:
- Shared package kmkz_ahb_pkg holds the AHB constants for the whole uRV bus fabric, reused by the bus matrix:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ)
  - HSIZE codes (BYTE/HALF/WORD)
  - HRESP codes (OKAY/ERROR)
  - the slave FSM state encoding
- One natural sub-module, kmkz_sram_bytewr: a single-port word RAM with 4-bit byte write enables and an asynchronous read port. Keeps the FSM separate from the storage so the RAM can later be swapped for a vendor BRAM.

Test Plan:
- WAIT_STATES=0. Word write 0xDEADBEEF @0x0010, then word read @0x0010 back-to-back -> HREADYOUT never low; read DATA cycle HRDATA=0xDEADBEEF, HRESP=0.
- Byte write 0xAA @0x0011 onto 0x00000000, half write 0x1234 @0x0016 onto 0xFFFFFFFF, then word reads -> 0x0000AA00 and 0x1234FFFF.
- WAIT_STATES=3. Word read @0x0020 -> HREADYOUT low exactly 3 cycles, then data valid on the 4th cycle after the address phase.
- Word read @0x0002 (misaligned), then separately HSIZE=011 -> each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1. RAM is unchanged, and a following legal NONSEQ issued in ERR2 completes OKAY.
- MEM_AW=10. Write @0x1000 (out of range) -> ERROR pair; word 0 still holds its prior value.
- WAIT_STATES=3. Assert rst_i during the 2nd wait cycle of a write 0x55 to @0x0030 -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately. Readback after reset shows the pre-reset contents, not 0x55.
